spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI master counterpart to the board's SPI slave port; used to drive slave boards and test fixtures from the same FPGA.
- Mode 3 (CPOL=1, CPHA=1), MSB first, full duplex, byte-wise; multi-byte bursts under one CS assertion.
- Sits between the command/control logic (valid/ready byte stream) and the physical SPI pins.

Parameters:
- CLK_DIV, 4, spi_clk half-period in clk_25m cycles (>=1).
- CS_SETUP, 2, clk_25m cycles from CS fall to the first spi_clk falling edge (>=1).
- CS_HOLD, 2, clk_25m cycles from the end of the last bit to CS rise (>=1).
- CS_IDLE, 2, minimum CS-high clk_25m cycles before the next burst may start (>=1).

Ports:
- clk_25m  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_valid  in  1  tx_byte valid
- tx_ready  out  1  master can take a byte; transfer on tx_valid&&tx_ready
- tx_byte  in  8  byte to shift out on MOSI
- tx_last  in  1  sampled with tx_byte; 1 = release CS after this byte
- rx_valid  out  1  one-cycle pulse, rx_byte updated
- rx_byte  out  8  byte captured from MISO
- busy  out  1  high whenever state != IDLE
- spi_clk  out  1  SPI clock, idles high
- spi_cs  out  1  chip select, active low
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

Behaviour:
- Reset (also mid-transfer, effective on the next edge): state=IDLE, spi_cs=1, spi_clk=1, spi_mosi=1, tx_ready=0 while rst=1, rx_valid=0, rx_byte=0x00, busy=0. A partial byte is discarded and no rx_valid is produced.
- All outputs are registered. A divider counter (0..CLK_DIV-1) runs only in SHIFT.
- IDLE:
  - tx_ready=1.
  - On accept, latch tx_byte into the shift register and tx_last into a flag, then go to SETUP.
  - spi_cs=0 from the next cycle.
- SETUP:
  - spi_clk=1 for CS_SETUP cycles, then go to SHIFT.
- SHIFT, per bit (2*CLK_DIV cycles):
  - spi_clk falls and spi_mosi takes the current MSB in the same cycle; low phase lasts CLK_DIV cycles.
  - spi_clk rises; in the same edge, spi_miso is shifted into the rx register LSB-side; high phase lasts CLK_DIV cycles.
  - Bit order is 7 down to 0.
  - A byte takes 16*CLK_DIV cycles.
- After the 8th rising edge:
  - rx_valid pulses in the cycle spi_clk is first high, with rx_byte = the full captured byte. rx_byte holds until the next pulse.
- Byte boundary (final high phase), when the latched last flag = 0:
  - tx_ready=1 throughout the final high phase.
  - If a byte is accepted before the phase ends, continue SHIFT with no gap.
  - Otherwise go to GAP: spi_cs=0, spi_clk=1, tx_ready=1, waiting indefinitely.
  - Accept in GAP: the next cycle begins bit 7 (falling edge).
- Byte boundary, when last flag = 1:
  - tx_ready=0; go to HOLD (spi_cs=0, spi_clk=1) for CS_HOLD cycles.
  - Then go to CSIDLE (spi_cs=1, tx_ready=0) for CS_IDLE cycles, then IDLE.
- spi_mosi returns to 1 when CS rises.
- tx_ready=0 in SETUP, HOLD and CSIDLE, and in SHIFT outside the final high phase. tx_valid in those states is ignored and held by the upstream.
- tx_byte/tx_last changes after acceptance have no effect.
- Timing example (CLK_DIV=2, CS_SETUP=2, accept at cycle 0):
  - spi_cs=0 at cycle 1.
  - Falls at cycles 3+4k, rises at 5+4k (k=0..7).
  - rx_valid at cycle 33; HOLD at 35–36; spi_cs=1 at 37; IDLE at 39.

Decomposition:
- Package spi_pkg: state encoding (IDLE, SETUP, SHIFT, GAP, HOLD, CSIDLE), idle levels (CS_IDLE_LVL=1, SCLK_IDLE_LVL=1), and a divider width function clog2.
- One sub-module, spi_half_tick: a parameterised CLK_DIV counter with enable and sync clear, emitting a half-period tick.

Test Plan:
- Reset: rst=1 for 3 cycles mid-byte -> next cycle spi_cs=1, spi_clk=1, spi_mosi=1, rx_valid=0, busy=0; no rx_valid afterwards.
- Single byte, MISO looped to MOSI, tx_byte=0xA5, tx_last=1, CLK_DIV=2 -> MOSI bits 1,0,1,0,0,1,0,1; rx_valid at cycle 33 with rx_byte=0xA5; spi_cs=1 at cycle 37.
- Back-to-back burst 0x3C,0xFF,0x00 (last on the third byte), tx_valid always high -> 24 contiguous spi_clk periods; CS low throughout; three rx_valid pulses exactly 16*CLK_DIV cycles apart.
- Starved upstream: send 0x81 (last=0), assert tx_valid 20 cycles late -> spi_clk stays high and spi_cs stays low in GAP; the next falling edge comes one cycle after the accept.
- Behavioural mode-3 slave model returning 0x5A -> rx_byte=0x5A; the slave receives the tx byte intact; CLK_DIV=1 and CLK_DIV=7 both pass.
- CS_IDLE enforcement: tx_valid held high across the end of a burst -> tx_ready stays 0 for CS_HOLD+CS_IDLE cycles; the new CS fall comes at least CS_IDLE cycles after the CS rise.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding, pin idle levels and sizing helper for the SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        HOLD,
        CSIDLE
    } spi_state_t;

    localparam logic CS_IDLE_LVL   = 1'b1;
    localparam logic SCLK_IDLE_LVL = 1'b1;

    // Never returns 0, so a divide-by-1 still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// spi_clk half-period timer: down-counts CLK_DIV-1..0 while enabled and ticks on terminal count.
module spi_half_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_25m,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV);
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_25m) begin
        if (rst || clr) begin
            cnt <= LOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? LOAD : cnt - CW'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-3 master: accepts a valid/ready byte stream and runs full-duplex,
// MSB-first bursts under a single chip select.
//
// state  | meaning
// IDLE   | CS high, ready for the first byte of a burst
// SETUP  | CS low, clock idle high for CS_SETUP cycles
// SHIFT  | clocking a byte, 2*CLK_DIV cycles per bit
// GAP    | mid-burst, CS low, waiting for the next byte
// HOLD   | last bit done, CS still low for CS_HOLD cycles
// CSIDLE | CS high for CS_IDLE cycles before a new burst
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk_25m,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_byte,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic       spi_clk,
    output logic       spi_cs,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int TMAX = (CS_SETUP > CS_HOLD)
                        ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                        : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int TW = clog2(TMAX + 1);

    spi_state_t    state;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          last_flag;
    logic          pend;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmr;
    logic          tick;
    logic          accept;

    assign accept = tx_valid && tx_ready;

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_25m (clk_25m),
        .rst     (rst),
        .en      (state == SHIFT),
        .clr     (state != SHIFT),
        .tick    (tick)
    );

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state     <= IDLE;
            spi_cs    <= CS_IDLE_LVL;
            spi_clk   <= SCLK_IDLE_LVL;
            spi_mosi  <= 1'b1;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_byte   <= 8'h00;
            busy      <= 1'b0;
            tx_sh     <= 8'h00;
            rx_sh     <= 8'h00;
            last_flag <= 1'b0;
            pend      <= 1'b0;
            bit_cnt   <= 3'd0;
            tmr       <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (accept) begin
                        tx_sh     <= tx_byte;
                        last_flag <= tx_last;
                        tx_ready  <= 1'b0;
                        spi_cs    <= ~CS_IDLE_LVL;
                        busy      <= 1'b1;
                        tmr       <= TW'(CS_SETUP - 1);
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (tmr == '0) begin
                        spi_clk  <= ~SCLK_IDLE_LVL;
                        spi_mosi <= tx_sh[7];
                        bit_cnt  <= 3'd7;
                        state    <= SHIFT;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                SHIFT: begin
                    // Only possible in the final high phase of a non-last byte.
                    if (accept) begin
                        tx_sh     <= tx_byte;
                        last_flag <= tx_last;
                        tx_ready  <= 1'b0;
                        pend      <= 1'b1;
                    end
                    if (tick) begin
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                            rx_sh   <= {rx_sh[6:0], spi_miso};
                            if (bit_cnt == 3'd0) begin
                                rx_byte  <= {rx_sh[6:0], spi_miso};
                                rx_valid <= 1'b1;
                                tx_ready <= !last_flag;
                            end
                        end else if (bit_cnt != 3'd0) begin
                            spi_clk  <= 1'b0;
                            spi_mosi <= tx_sh[bit_cnt - 3'd1];
                            bit_cnt  <= bit_cnt - 3'd1;
                        end else if (accept || pend) begin
                            // last_flag may already belong to the next byte here.
                            spi_clk  <= 1'b0;
                            spi_mosi <= accept ? tx_byte[7] : tx_sh[7];
                            bit_cnt  <= 3'd7;
                            pend     <= 1'b0;
                            tx_ready <= 1'b0;
                        end else if (last_flag) begin
                            tmr   <= TW'(CS_HOLD - 1);
                            state <= HOLD;
                        end else begin
                            state <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (accept) begin
                        tx_sh     <= tx_byte;
                        last_flag <= tx_last;
                        tx_ready  <= 1'b0;
                        spi_clk   <= 1'b0;
                        spi_mosi  <= tx_byte[7];
                        bit_cnt   <= 3'd7;
                        state     <= SHIFT;
                    end
                end

                HOLD: begin
                    if (tmr == '0) begin
                        spi_cs   <= CS_IDLE_LVL;
                        spi_mosi <= 1'b1;
                        tmr      <= TW'(CS_IDLE - 1);
                        state    <= CSIDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                CSIDLE: begin
                    if (tmr == '0) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: three instances (CLK_DIV 2, 1, 7), each with a mode-3 slave model.
module tb_spi_master_ctrl;

    localparam int N = 3;

    logic clk_25m = 1'b0;
    logic rst     = 1'b1;

    logic [N-1:0]      tx_valid = '0;
    logic [N-1:0]      tx_last  = '0;
    logic [N-1:0]      loopback = '0;
    logic [N-1:0][7:0] tx_byte  = '0;
    logic [N-1:0]      tx_ready, rx_valid, busy, spi_clk, spi_cs, spi_mosi, spi_miso;
    logic [N-1:0][7:0] rx_byte;

    int total = 0;
    int bad   = 0;

    logic       r_clk  [0:127];
    logic       r_cs   [0:127];
    logic       r_mosi [0:127];
    logic       r_rv   [0:127];
    logic       r_rdy  [0:127];
    logic [7:0] r_rx   [0:127];

    always #20 clk_25m = ~clk_25m;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 2 : (g == 1) ? 1 : 7;
        logic [7:0] slv_rx   = 8'h00;
        logic [7:0] slv_got  = 8'h00;
        logic [7:0] slv_byte = 8'h5A;
        logic [2:0] slv_cnt  = 3'd0;
        logic       slv_miso = 1'b1;

        spi_master_ctrl #(
            .CLK_DIV  (DIV),
            .CS_SETUP (2),
            .CS_HOLD  (2),
            .CS_IDLE  (2)
        ) u_dut (
            .clk_25m  (clk_25m),
            .rst      (rst),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .tx_byte  (tx_byte[g]),
            .tx_last  (tx_last[g]),
            .rx_valid (rx_valid[g]),
            .rx_byte  (rx_byte[g]),
            .busy     (busy[g]),
            .spi_clk  (spi_clk[g]),
            .spi_cs   (spi_cs[g]),
            .spi_mosi (spi_mosi[g]),
            .spi_miso (spi_miso[g])
        );

        // Mode-3 slave: samples MOSI on the rising edge, drives MISO on the falling edge.
        always @(posedge spi_clk[g] or posedge spi_cs[g]) begin
            if (spi_cs[g]) begin
                slv_cnt <= 3'd0;
            end else begin
                slv_rx <= {slv_rx[6:0], spi_mosi[g]};
                if (slv_cnt == 3'd7) slv_got <= {slv_rx[6:0], spi_mosi[g]};
                slv_cnt <= slv_cnt + 3'd1;
            end
        end

        always @(negedge spi_clk[g]) begin
            if (!spi_cs[g]) slv_miso <= slv_byte[3'd7 - slv_cnt];
        end

        assign spi_miso[g] = loopback[g] ? spi_mosi[g] : slv_miso;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rec(input int c);
        @(negedge clk_25m);
        r_clk[c]  = spi_clk[0];
        r_cs[c]   = spi_cs[0];
        r_mosi[c] = spi_mosi[0];
        r_rv[c]   = rx_valid[0];
        r_rdy[c]  = tx_ready[0];
        r_rx[c]   = rx_byte[0];
    endtask

    task automatic wait_ready(input int g);
        int n;
        n = 0;
        while (!tx_ready[g] && n < 300) begin
            @(negedge clk_25m);
            n++;
        end
        chk($sformatf("ready_wait%0d", g), tx_ready[g], 1);
    endtask

    // Edges of spi_clk reaching level lvl at cycles start, start+step, ...
    function automatic int n_edges(input int start, input int step, input int n, input logic lvl);
        int k;
        k = 0;
        for (int i = 0; i < n; i++)
            if (r_clk[start + i*step - 1] != lvl && r_clk[start + i*step] == lvl) k++;
        return k;
    endfunction

    function automatic int n_rv(input int a, input int b);
        int k;
        k = 0;
        for (int c = a; c <= b; c++) if (r_rv[c]) k++;
        return k;
    endfunction

    function automatic int first_rv(input int a, input int b);
        for (int c = a; c <= b; c++) if (r_rv[c]) return c;
        return -1;
    endfunction

    function automatic int first_cs(input int a, input int b, input logic lvl);
        for (int c = a; c <= b; c++) if (r_cs[c] == lvl) return c;
        return -1;
    endfunction

    function automatic int n_cs_low(input int a, input int b);
        int k;
        k = 0;
        for (int c = a; c <= b; c++) if (!r_cs[c]) k++;
        return k;
    endfunction

    function automatic int n_rdy(input int a, input int b);
        int k;
        k = 0;
        for (int c = a; c <= b; c++) if (r_rdy[c]) k++;
        return k;
    endfunction

    function automatic logic [7:0] mosi_byte(input int start);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[7-k] = r_mosi[start + 4*k];
        return b;
    endfunction

    task automatic slave_xfer(input int g, input logic [7:0] b, input int exp_lat);
        int lat;
        int n;
        logic [7:0] got;
        wait_ready(g);
        tx_byte[g]  = b;
        tx_last[g]  = 1'b1;
        tx_valid[g] = 1'b1;
        @(posedge clk_25m);
        #1 tx_valid[g] = 1'b0;
        lat = 0;
        while (!rx_valid[g] && lat < 200) begin
            @(negedge clk_25m);
            lat++;
        end
        chk($sformatf("slv%0d_latency", g), lat, exp_lat);
        chk($sformatf("slv%0d_rx", g), rx_byte[g], 8'h5A);
        n = 0;
        while (busy[g] && n < 300) begin
            @(negedge clk_25m);
            n++;
        end
        chk($sformatf("slv%0d_done", g), busy[g], 0);
        got = (g == 0) ? g_dut[0].slv_got : (g == 1) ? g_dut[1].slv_got : g_dut[2].slv_got;
        chk($sformatf("slv%0d_mosi", g), got, b);
    endtask

    initial begin
        logic       will;
        int         idx;
        int         rise;
        int         fall;
        logic [7:0] bq [3];

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk_25m);
        chk("rst_cs", spi_cs[0], 1);
        chk("rst_clk", spi_clk[0], 1);
        chk("rst_mosi", spi_mosi[0], 1);
        chk("rst_ready", tx_ready[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_rv", rx_valid[0], 0);
        chk("rst_rxbyte", rx_byte[0], 8'h00);
        rst = 1'b0;
        loopback = 3'b001;

        // Single byte 0xA5, last, looped back
        wait_ready(0);
        tx_byte[0]  = 8'hA5;
        tx_last[0]  = 1'b1;
        tx_valid[0] = 1'b1;
        @(posedge clk_25m);
        #1;
        tx_valid[0] = 1'b0;
        tx_byte[0]  = 8'h00;
        tx_last[0]  = 1'b0;
        for (int c = 1; c <= 45; c++) rec(c);
        chk("a5_setup", {r_cs[1], r_clk[1], r_clk[2], r_clk[3]}, 4'b0110);
        chk("a5_falls", n_edges(3, 4, 8, 1'b0), 8);
        chk("a5_rises", n_edges(5, 4, 8, 1'b1), 8);
        chk("a5_mosi", mosi_byte(3), 8'hA5);
        chk("a5_rv_cycle", first_rv(1, 45), 33);
        chk("a5_rv_count", n_rv(1, 45), 1);
        chk("a5_rx", r_rx[33], 8'hA5);
        chk("a5_cs_low", n_cs_low(1, 45), 36);
        chk("a5_cs_rise", {r_cs[36], r_cs[37], r_mosi[37]}, 3'b011);
        chk("a5_ready", {r_rdy[33], r_rdy[38], r_rdy[39]}, 3'b001);
        chk("a5_rx_hold", r_rx[45], 8'hA5);

        // Back-to-back burst with tx_valid always high
        bq = '{8'h3C, 8'hFF, 8'h00};
        wait_ready(0);
        idx = 0;
        tx_byte[0]  = bq[0];
        tx_last[0]  = 1'b0;
        tx_valid[0] = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            will = tx_valid[0] && tx_ready[0];
            rec(c);
            if (will) begin
                idx++;
                if (idx < 3) begin
                    tx_byte[0] = bq[idx];
                    tx_last[0] = (idx == 2);
                end else begin
                    tx_valid[0] = 1'b0;
                end
            end
        end
        chk("burst_falls_at", n_edges(3, 4, 24, 1'b0), 24);
        chk("burst_falls_all", n_edges(2, 1, 109, 1'b0), 24);
        chk("burst_rv_count", n_rv(1, 110), 3);
        chk("burst_rv_at", {r_rv[33], r_rv[65], r_rv[97]}, 3'b111);
        chk("burst_rx0", r_rx[33], 8'h3C);
        chk("burst_rx1", r_rx[65], 8'hFF);
        chk("burst_rx2", r_rx[97], 8'h00);
        chk("burst_cs_low", n_cs_low(1, 110), 100);
        chk("burst_cs_rise", r_cs[101], 1);

        // Starved upstream: 0x81 (not last), next byte offered 20 cycles into GAP
        wait_ready(0);
        tx_byte[0]  = 8'h81;
        tx_last[0]  = 1'b0;
        tx_valid[0] = 1'b1;
        for (int c = 1; c <= 95; c++) begin
            will = tx_valid[0] && tx_ready[0];
            rec(c);
            if (will) tx_valid[0] = 1'b0;
            if (c == 55) begin
                tx_byte[0]  = 8'h42;
                tx_last[0]  = 1'b1;
                tx_valid[0] = 1'b1;
            end
        end
        chk("gap_rx0", r_rx[33], 8'h81);
        chk("gap_idle_clk", n_edges(36, 1, 20, 1'b0), 0);
        chk("gap_clk_high", {r_clk[35], r_clk[45], r_clk[55]}, 3'b111);
        chk("gap_cs_low", n_cs_low(35, 55), 21);
        chk("gap_ready", n_rdy(33, 55), 23);
        chk("gap_fall", {r_clk[55], r_clk[56]}, 2'b10);
        chk("gap_mosi1", mosi_byte(56), 8'h42);
        chk("gap_rx1", {r_rv[86], r_rx[86]}, {1'b1, 8'h42});
        chk("gap_cs_rise", first_cs(2, 95, 1'b1), 90);

        // CS idle enforcement: tx_valid stays high across the end of a burst
        wait_ready(0);
        idx = 0;
        tx_byte[0]  = 8'h11;
        tx_last[0]  = 1'b1;
        tx_valid[0] = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            will = tx_valid[0] && tx_ready[0];
            rec(c);
            if (will) begin
                idx++;
                if (idx == 1) tx_byte[0] = 8'h22;
                else tx_valid[0] = 1'b0;
            end
        end
        rise = first_cs(2, 80, 1'b1);
        fall = first_cs(38, 80, 1'b0);
        chk("csi_ready_low", n_rdy(1, 38), 0);
        chk("csi_ready_back", r_rdy[39], 1);
        chk("csi_cs_rise", rise, 37);
        chk("csi_cs_fall", fall, 40);
        chk("csi_cs_high_len", fall - rise, 3);
        chk("csi_rx", {r_rx[33], r_rx[72]}, 16'h1122);

        // Reset in the middle of a byte
        wait_ready(0);
        tx_byte[0]  = 8'h77;
        tx_last[0]  = 1'b1;
        tx_valid[0] = 1'b1;
        @(posedge clk_25m);
        #1 tx_valid[0] = 1'b0;
        repeat (10) @(negedge clk_25m);
        chk("mid_cs_low", spi_cs[0], 0);
        rst = 1'b1;
        @(negedge clk_25m);
        chk("mid_rst_pins", {spi_cs[0], spi_clk[0], spi_mosi[0]}, 3'b111);
        chk("mid_rst_flags", {rx_valid[0], busy[0], tx_ready[0]}, 3'b000);
        chk("mid_rst_rxbyte", rx_byte[0], 8'h00);
        repeat (2) @(negedge clk_25m);
        rst = 1'b0;
        for (int c = 1; c <= 60; c++) rec(c);
        chk("mid_no_rv", n_rv(1, 60), 0);
        chk("mid_cs_high", n_cs_low(1, 60), 0);

        // Behavioural slave returning 0x5A at three divider settings
        loopback = 3'b000;
        slave_xfer(0, 8'hC3, 33);
        slave_xfer(1, 8'h96, 18);
        slave_xfer(2, 8'h3E, 108);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
